ddr2_burst_scheduler: RTL and testbench

Sequences and arbitrates the single SDRAM p0 command port between the input-side write mover and the output-side read mover.
Owns the ring-buffer write/read byte pointers and the fill level, and latches the burst length per transaction.
Grants one mover at a time, then issues the matching MIG command.
Sits between the USB/acquisition FIFOs and the MIG user port; data movement itself stays in the movers.

---
 rtl/ddr2_pkg.sv | 17 +
 rtl/ddr2_ring_ptr.sv | 26 ++
 rtl/ddr2_burst_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_ddr2_burst_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_pkg.sv
// Shared definitions for the DDR2 burst scheduler: FSM encoding, MIG command codes, FIFO depth.
package ddr2_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_GRANT = 3'd1,
      WR_CMD   = 3'd2,
      RD_CMD   = 3'd3,
      RD_GRANT = 3'd4
   } state_t;

   localparam logic [2:0] CMD_WR = 3'b000;
   localparam logic [2:0] CMD_RD = 3'b001;

   localparam int unsigned FIFO_SIZE = 2048;

endpackage

// File: rtl/ddr2_ring_ptr.sv
// Ring-buffer byte pointer; advances by a step and wraps to 0 at RING_BYTES (a power of two).
module ddr2_ring_ptr #(
   parameter int unsigned ADDR_W     = 30,
   parameter int unsigned RING_BYTES = 134217728
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              adv,
   input  logic [ADDR_W-1:0] step,
   output logic [ADDR_W-1:0] ptr
);

   localparam int unsigned    AW1    = ADDR_W + 1;
   localparam logic [AW1-1:0] RING_W = AW1'(RING_BYTES);
   localparam logic [ADDR_W-1:0] MASK = ADDR_W'(RING_W - AW1'(1));

   // Pointer register; masking implements the power-of-two modulo wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (adv) begin
         ptr <= (ptr + step) & MASK;
      end
   end

endmodule

// File: rtl/ddr2_burst_scheduler.sv
// Arbitrates the SDRAM p0 command port between the write and read movers,
// owns the ring pointers and fill level, and issues the matching MIG command.
module ddr2_burst_scheduler
   import ddr2_pkg::*;
#(
   parameter int unsigned ADDR_W     = 30,
   parameter int unsigned RING_BYTES = 134217728,
   parameter int unsigned MAX_BL     = 64,
   parameter int unsigned IB_HIGH    = 1536
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              calib_done,
   input  logic              writes_en,
   input  logic              reads_en,
   input  logic [31:0]       ddr_burst_len,
   input  logic              burst_override,
   input  logic [10:0]       ib_count,
   input  logic [10:0]       ob_count,
   output logic              wr_grant,
   input  logic              wr_done,
   output logic              rd_grant,
   input  logic              rd_done,
   output logic [6:0]        active_len,
   input  logic              p0_cmd_full,
   output logic              p0_cmd_en,
   output logic [2:0]        p0_cmd_instr,
   output logic [5:0]        p0_cmd_bl,
   output logic [ADDR_W-1:0] p0_cmd_byte_addr,
   output logic [ADDR_W-1:0] cmd_byte_addr_wr,
   output logic [ADDR_W-1:0] cmd_byte_addr_rd,
   output logic [ADDR_W:0]   fill_bytes,
   output logic              ring_full,
   output logic              overflow_err
);

   localparam int unsigned    AW1       = ADDR_W + 1;
   localparam int unsigned    AW2       = ADDR_W + 2;
   localparam logic [AW2-1:0] RING_W    = AW2'(RING_BYTES);
   localparam logic [AW2-1:0] MAX_BYTES = AW2'(4 * MAX_BL);
   localparam logic [11:0]    OB_LIMIT  = 12'(FIFO_SIZE - 1);

   state_t         state;
   state_t         state_nxt;
   logic [31:0]    req_len;
   logic [6:0]     len_c;
   logic [AW2-1:0] len_bytes_c;
   logic [AW2-1:0] fill_ext;
   logic [AW2-1:0] act_bytes;
   logic           w_ok;
   logic           r_ok;
   logic           pick_wr;
   logic           last_op_wr;
   logic           wr_commit;
   logic           rd_issue;
   logic           rd_commit;
   logic [ADDR_W-1:0] step_bytes;

   // Burst length sanitize: even, clamped to [2, MAX_BL], or 2 when flushing.
   always_comb begin
      req_len = ddr_burst_len & ~32'd1;
      len_c   = 7'd2;
      if (!burst_override) begin
         if (req_len > 32'(MAX_BL)) begin
            len_c = 7'(MAX_BL);
         end else if (req_len >= 32'd2) begin
            len_c = 7'(req_len);
         end
      end
   end

   assign len_bytes_c = AW2'({len_c, 2'b00});
   assign fill_ext    = {1'b0, fill_bytes};
   assign act_bytes   = AW2'({active_len, 2'b00});
   assign step_bytes  = ADDR_W'({active_len, 2'b00});

   // Eligibility and arbitration; only consulted while IDLE.
   always_comb begin
      w_ok = calib_done & writes_en
           & ({4'b0, len_c} <= ib_count)
           & ((fill_ext + len_bytes_c) <= RING_W);
      r_ok = calib_done & reads_en
           & (fill_ext >= len_bytes_c)
           & ({1'b0, ob_count} < (OB_LIMIT - {5'b0, len_c}));
      pick_wr = w_ok & (~r_ok | (ib_count >= 11'(IB_HIGH)) | ~last_op_wr);
   end

   assign wr_commit = (state == WR_CMD) & ~p0_cmd_full;
   assign rd_issue  = (state == RD_CMD) & ~p0_cmd_full;
   assign rd_commit = (state == RD_GRANT) & rd_done;

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (w_ok | r_ok) state_nxt = pick_wr ? WR_GRANT : RD_CMD;
         WR_GRANT: if (wr_done)     state_nxt = WR_CMD;
         WR_CMD:   if (!p0_cmd_full) state_nxt = IDLE;
         RD_CMD:   if (!p0_cmd_full) state_nxt = RD_GRANT;
         RD_GRANT: if (rd_done)     state_nxt = IDLE;
         default:                   state_nxt = IDLE;
      endcase
   end

   // FSM outputs decoded from state; command strobe is held off while the MIG FIFO is full.
   always_comb begin
      wr_grant         = 1'b0;
      rd_grant         = 1'b0;
      p0_cmd_en        = 1'b0;
      p0_cmd_instr     = CMD_WR;
      p0_cmd_byte_addr = cmd_byte_addr_wr;
      case (state)
         WR_GRANT: wr_grant = 1'b1;
         WR_CMD:   p0_cmd_en = ~p0_cmd_full;
         RD_CMD: begin
            p0_cmd_en        = ~p0_cmd_full;
            p0_cmd_instr     = CMD_RD;
            p0_cmd_byte_addr = cmd_byte_addr_rd;
         end
         RD_GRANT: rd_grant = 1'b1;
         default: ;
      endcase
   end

   // Per-transaction latches, fill level and sticky overflow flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active_len   <= '0;
         p0_cmd_bl    <= '0;
         last_op_wr   <= 1'b0;
         fill_bytes   <= '0;
         overflow_err <= 1'b0;
      end else begin
         if ((state == IDLE) && (w_ok | r_ok)) begin
            active_len <= len_c;
            p0_cmd_bl  <= 6'(len_c - 7'd1);
            last_op_wr <= pick_wr;
         end
         if (wr_commit) begin
            fill_bytes <= fill_bytes + AW1'({active_len, 2'b00});
            if ((fill_ext + act_bytes) > RING_W) begin
               overflow_err <= 1'b1;
            end
         end else if (rd_commit) begin
            fill_bytes <= fill_bytes - AW1'({active_len, 2'b00});
         end
      end
   end

   assign ring_full = (fill_ext + MAX_BYTES) > RING_W;

   ddr2_ring_ptr #(
      .ADDR_W     (ADDR_W),
      .RING_BYTES (RING_BYTES)
   ) u_wr_ptr (
      .clk   (clk),
      .reset (reset),
      .adv   (wr_commit),
      .step  (step_bytes),
      .ptr   (cmd_byte_addr_wr)
   );

   ddr2_ring_ptr #(
      .ADDR_W     (ADDR_W),
      .RING_BYTES (RING_BYTES)
   ) u_rd_ptr (
      .clk   (clk),
      .reset (reset),
      .adv   (rd_issue),
      .step  (step_bytes),
      .ptr   (cmd_byte_addr_rd)
   );

endmodule

// File: tb/tb_ddr2_burst_scheduler.sv
// Directed bench for ddr2_burst_scheduler on a 1 KiB ring.
module tb_ddr2_burst_scheduler;

   localparam int unsigned ADDR_W = 30;
   localparam int unsigned RING   = 1024;

   logic              clk = 1'b0;
   logic              reset;
   logic              calib_done;
   logic              writes_en;
   logic              reads_en;
   logic [31:0]       ddr_burst_len;
   logic              burst_override;
   logic [10:0]       ib_count;
   logic [10:0]       ob_count;
   logic              wr_grant;
   logic              wr_done;
   logic              rd_grant;
   logic              rd_done;
   logic [6:0]        active_len;
   logic              p0_cmd_full;
   logic              p0_cmd_en;
   logic [2:0]        p0_cmd_instr;
   logic [5:0]        p0_cmd_bl;
   logic [ADDR_W-1:0] p0_cmd_byte_addr;
   logic [ADDR_W-1:0] cmd_byte_addr_wr;
   logic [ADDR_W-1:0] cmd_byte_addr_rd;
   logic [ADDR_W:0]   fill_bytes;
   logic              ring_full;
   logic              overflow_err;

   int n_total = 0;
   int n_bad   = 0;

   typedef struct {
      logic [31:0] len;
      logic        ovr;
      int          exp_len;
   } vec_t;

   vec_t vecs[8];

   always #5 clk = ~clk;

   ddr2_burst_scheduler #(
      .ADDR_W     (ADDR_W),
      .RING_BYTES (RING),
      .MAX_BL     (64),
      .IB_HIGH    (1536)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .calib_done       (calib_done),
      .writes_en        (writes_en),
      .reads_en         (reads_en),
      .ddr_burst_len    (ddr_burst_len),
      .burst_override   (burst_override),
      .ib_count         (ib_count),
      .ob_count         (ob_count),
      .wr_grant         (wr_grant),
      .wr_done          (wr_done),
      .rd_grant         (rd_grant),
      .rd_done          (rd_done),
      .active_len       (active_len),
      .p0_cmd_full      (p0_cmd_full),
      .p0_cmd_en        (p0_cmd_en),
      .p0_cmd_instr     (p0_cmd_instr),
      .p0_cmd_bl        (p0_cmd_bl),
      .p0_cmd_byte_addr (p0_cmd_byte_addr),
      .cmd_byte_addr_wr (cmd_byte_addr_wr),
      .cmd_byte_addr_rd (cmd_byte_addr_rd),
      .fill_bytes       (fill_bytes),
      .ring_full        (ring_full),
      .overflow_err     (overflow_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      calib_done     = 1'b0;
      writes_en      = 1'b0;
      reads_en       = 1'b0;
      ddr_burst_len  = 32'd0;
      burst_override = 1'b0;
      ib_count       = 11'd0;
      ob_count       = 11'd0;
      wr_done        = 1'b0;
      rd_done        = 1'b0;
      p0_cmd_full    = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   // Full write transaction: grant, done pulse, optional backpressure, command.
   task automatic do_write(input string nm, input int exp_len, input int exp_addr,
                           input int full_cycles, input bit drop_en, output int lat);
      int  n;
      logic en_seen;
      n = 0;
      while (!wr_grant && n < 20) begin
         tick();
         n++;
      end
      lat = n;
      chk({nm, " wr_grant"}, wr_grant, 1);
      chk({nm, " active_len"}, active_len, exp_len);
      if (drop_en) writes_en = 1'b0;
      tick();
      chk({nm, " grant held"}, wr_grant, 1);
      p0_cmd_full = (full_cycles > 0);
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
      chk({nm, " grant drop"}, wr_grant, 0);
      en_seen = 1'b0;
      for (int i = 0; i < full_cycles; i++) begin
         en_seen |= p0_cmd_en;
         tick();
      end
      if (full_cycles > 0) chk({nm, " en while full"}, en_seen, 0);
      p0_cmd_full = 1'b0;
      #1;
      chk({nm, " cmd_en"}, p0_cmd_en, 1);
      chk({nm, " instr"}, p0_cmd_instr, 3'b000);
      chk({nm, " addr"}, p0_cmd_byte_addr, exp_addr);
      chk({nm, " bl"}, p0_cmd_bl, exp_len - 1);
      tick();
      chk({nm, " en once"}, p0_cmd_en, 0);
   endtask

   // Full read transaction: command first, then grant until done.
   task automatic do_read(input string nm, input int exp_len, input int exp_addr);
      int n;
      n = 0;
      while (!(p0_cmd_en && p0_cmd_instr == 3'b001) && n < 20) begin
         tick();
         n++;
      end
      chk({nm, " rd cmd seen"}, (p0_cmd_en && p0_cmd_instr == 3'b001), 1);
      chk({nm, " addr"}, p0_cmd_byte_addr, exp_addr);
      chk({nm, " bl"}, p0_cmd_bl, exp_len - 1);
      chk({nm, " active_len"}, active_len, exp_len);
      tick();
      chk({nm, " rd_grant"}, rd_grant, 1);
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
      chk({nm, " rd_grant drop"}, rd_grant, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int   lat;
      logic any_act;

      vecs[0] = '{32'd0,   1'b0, 2};
      vecs[1] = '{32'd7,   1'b0, 6};
      vecs[2] = '{32'd200, 1'b0, 64};
      vecs[3] = '{32'd32,  1'b1, 2};
      vecs[4] = '{32'd1,   1'b0, 2};
      vecs[5] = '{32'd64,  1'b0, 64};
      vecs[6] = '{32'd65,  1'b0, 64};
      vecs[7] = '{32'd3,   1'b0, 2};

      // Reset state
      do_reset();
      chk("rst wr_grant", wr_grant, 0);
      chk("rst rd_grant", rd_grant, 0);
      chk("rst cmd_en", p0_cmd_en, 0);
      chk("rst active_len", active_len, 0);
      chk("rst bl", p0_cmd_bl, 0);
      chk("rst addr", p0_cmd_byte_addr, 0);
      chk("rst fill", fill_bytes, 0);
      chk("rst ring_full", ring_full, 0);
      chk("rst ovf", overflow_err, 0);

      // Write then read, with stray done pulses and the ob_count boundary
      calib_done    = 1'b1;
      writes_en     = 1'b1;
      ib_count      = 11'd100;
      ddr_burst_len = 32'd32;
      do_write("t1 w", 32, 0, 0, 1'b1, lat);
      chk("t1 grant latency", lat, 1);
      chk("t1 fill", fill_bytes, 128);
      chk("t1 wr ptr", cmd_byte_addr_wr, 128);
      wr_done = 1'b1;
      rd_done = 1'b1;
      tick();
      wr_done = 1'b0;
      rd_done = 1'b0;
      chk("t1 stray fill", fill_bytes, 128);
      chk("t1 stray grant", wr_grant | rd_grant, 0);
      reads_en = 1'b1;
      ob_count = 11'd2015;
      any_act  = 1'b0;
      repeat (3) begin
         tick();
         any_act |= p0_cmd_en | rd_grant | wr_grant;
      end
      chk("t1 ob limit blocks", any_act, 0);
      ob_count = 11'd2014;
      do_read("t1 r", 32, 0);
      chk("t1 fill after read", fill_bytes, 0);
      chk("t1 rd ptr", cmd_byte_addr_rd, 128);

      // Length sanitize table
      for (int i = 0; i < 8; i++) begin
         do_reset();
         calib_done     = 1'b1;
         writes_en      = 1'b1;
         ib_count       = 11'd100;
         ddr_burst_len  = vecs[i].len;
         burst_override = vecs[i].ovr;
         do_write($sformatf("san%0d", i), vecs[i].exp_len, 0, 0, 1'b1, lat);
         chk($sformatf("san%0d fill", i), fill_bytes, 4 * vecs[i].exp_len);
      end

      // Contention: ties alternate, high ib_count forces writes
      do_reset();
      calib_done    = 1'b1;
      ddr_burst_len = 32'd32;
      ib_count      = 11'd100;
      writes_en     = 1'b1;
      do_write("c w0", 32, 0, 0, 1'b0, lat);
      do_write("c w1", 32, 128, 0, 1'b0, lat);
      reads_en = 1'b1;
      do_read("c r0", 32, 0);
      do_write("c w2", 32, 256, 0, 1'b0, lat);
      do_read("c r1", 32, 128);
      chk("c fill mid", fill_bytes, 128);
      ib_count = 11'd1600;
      do_write("c h0", 32, 384, 0, 1'b0, lat);
      do_write("c h1", 32, 512, 0, 1'b0, lat);
      do_write("c h2", 32, 640, 0, 1'b1, lat);
      chk("c fill end", fill_bytes, 512);

      // Command backpressure
      do_reset();
      calib_done    = 1'b1;
      ddr_burst_len = 32'd16;
      ib_count      = 11'd100;
      writes_en     = 1'b1;
      do_write("bp", 16, 0, 10, 1'b1, lat);
      chk("bp fill", fill_bytes, 64);

      // Wrap, ring_full and fill limit on the 1 KiB ring
      do_reset();
      calib_done    = 1'b1;
      ddr_burst_len = 32'd64;
      ib_count      = 11'd100;
      writes_en     = 1'b1;
      do_write("wr0", 64, 0, 0, 1'b0, lat);
      do_write("wr1", 64, 256, 0, 1'b0, lat);
      do_write("wr2", 64, 512, 0, 1'b0, lat);
      chk("wrap ring_full 768", ring_full, 0);
      do_write("wr3", 64, 768, 0, 1'b0, lat);
      chk("wrap fill 1024", fill_bytes, 1024);
      chk("wrap ring_full 1024", ring_full, 1);
      chk("wrap wr ptr", cmd_byte_addr_wr, 0);
      ib_count = 11'd2047;
      any_act  = 1'b0;
      repeat (5) begin
         tick();
         any_act |= wr_grant | p0_cmd_en;
      end
      chk("wrap full blocks write", any_act, 0);
      reads_en = 1'b1;
      do_read("wrap rd", 64, 0);
      chk("wrap fill 768", fill_bytes, 768);
      do_write("wr4", 64, 0, 0, 1'b1, lat);
      chk("wrap fill back", fill_bytes, 1024);
      chk("wrap ovf", overflow_err, 0);

      // Asynchronous reset in WR_GRANT
      do_reset();
      calib_done    = 1'b1;
      ddr_burst_len = 32'd32;
      ib_count      = 11'd100;
      writes_en     = 1'b1;
      do_write("r w0", 32, 0, 0, 1'b0, lat);
      lat = 0;
      while (!wr_grant && lat < 20) begin
         tick();
         lat++;
      end
      chk("r grant before reset", wr_grant, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("r async grant", wr_grant, 0);
      chk("r async len", active_len, 0);
      chk("r async fill", fill_bytes, 0);
      chk("r async ptr", cmd_byte_addr_wr, 0);
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
      chk("r no cmd", p0_cmd_en, 0);
      reset = 1'b0;
      do_write("r w1", 32, 0, 0, 1'b1, lat);
      chk("r fill", fill_bytes, 128);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
